// File: rtl/instruction_assembler_if.sv
// Fetch-side bus of the instruction assembler: slice data and load controls in, assembled instruction and status out.
// IR_SHADOW_EN adds the IRPrev shadow output.
interface instruction_assembler_if #(
    parameter int SLICE_W = 8,
    parameter int SLICES  = 2
);
    localparam int INSTR_W = SLICE_W * SLICES;
    localparam int PTR_W   = $clog2(SLICES);

    logic [SLICE_W-1:0] I;
    logic               Write;
    logic               Mode;
    logic [PTR_W-1:0]   Sel;
    logic               Clear;
    logic               Ack;
    logic [INSTR_W-1:0] IROut;
    logic               Valid;
    logic               Stall;
    logic [PTR_W-1:0]   Ptr;
`ifdef IR_SHADOW_EN
    logic [INSTR_W-1:0] IRPrev;

    modport master (output I, Write, Mode, Sel, Clear, Ack,
                    input  IROut, Valid, Stall, Ptr, IRPrev);
    modport slave  (input  I, Write, Mode, Sel, Clear, Ack,
                    output IROut, Valid, Stall, Ptr, IRPrev);
`else
    modport master (output I, Write, Mode, Sel, Clear, Ack,
                    input  IROut, Valid, Stall, Ptr);
    modport slave  (input  I, Write, Mode, Sel, Clear, Ack,
                    output IROut, Valid, Stall, Ptr);
`endif
endinterface

// File: rtl/instruction_assembler.sv
// Instruction register assembling SLICES fetch slices into one instruction, direct or auto-pointer load.
// Optional IR_SHADOW_EN keeps the last acknowledged instruction on IRPrev.
module instruction_assembler #(
    parameter int SLICE_W = 8,
    parameter int SLICES  = 2
) (
    input  logic Clock,
    input  logic Reset,
    instruction_assembler_if.slave bus
);
    localparam int INSTR_W = SLICE_W * SLICES;
    localparam int PTR_W   = $clog2(SLICES);
    localparam logic [PTR_W:0]   SLICE_LIM = (PTR_W + 1)'(SLICES);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SLICES - 1);

    logic [SLICE_W-1:0] slice_reg [SLICES];
    logic [INSTR_W-1:0] ir;
    logic [PTR_W-1:0]   ptr_reg, ptr_next, write_idx;
    logic [SLICES-1:0]  loaded_reg, loaded_next, slice_we;
    logic               valid_reg, stall, write_ok, ack_eff;

    always_comb begin
        stall     = bus.Mode & valid_reg & ~bus.Ack;
        write_idx = bus.Mode ? ptr_reg : bus.Sel;
        ack_eff   = bus.Ack & valid_reg;
        // Direct mode never stalls; out-of-range Sel simply drops the write.
        write_ok  = bus.Write & ~bus.Clear &
                    (bus.Mode ? ~stall : ({1'b0, bus.Sel} < SLICE_LIM));
        ptr_next  = ptr_reg;
        if (write_ok && bus.Mode)
            ptr_next = (ptr_reg == LAST_PTR) ? '0 : ptr_reg + 1'b1;
        // Ack clears the mask before a same-edge write sets its bit.
        loaded_next = ack_eff ? '0 : loaded_reg;
        loaded_next = loaded_next | slice_we;
    end

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slice_we[gi] = write_ok & (write_idx == PTR_W'(gi));
            assign ir[gi*SLICE_W +: SLICE_W] = slice_reg[gi];

            always_ff @(posedge Clock) begin
                if (Reset)
                    slice_reg[gi] <= '0;
                else if (slice_we[gi])
                    slice_reg[gi] <= bus.I;
            end
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset || bus.Clear) begin
            ptr_reg    <= '0;
            loaded_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            loaded_reg <= loaded_next;
            valid_reg  <= &loaded_next;
        end
    end

`ifdef IR_SHADOW_EN
    logic [INSTR_W-1:0] ir_prev_reg;

    always_ff @(posedge Clock) begin
        if (Reset)
            ir_prev_reg <= '0;
        else if (ack_eff)
            ir_prev_reg <= ir;
    end

    assign bus.IRPrev = ir_prev_reg;
`endif

    assign bus.IROut = ir;
    assign bus.Valid = valid_reg;
    assign bus.Stall = stall;
    assign bus.Ptr   = ptr_reg;
endmodule
